// File: rtl/pll_reconfig_responder.sv
// Responder side of the PLL reconfiguration parameter interface: shadow registers
// for M/N high/low counts, register read/write, and serial scan-out into the PLL.
module pll_reconfig_responder #(
    parameter logic [8:0] DEF_M_HI  = 9'd4,
    parameter logic [8:0] DEF_M_LO  = 9'd4,
    parameter logic [8:0] DEF_N_HI  = 9'd1,
    parameter logic [8:0] DEF_N_LO  = 9'd1,
    parameter int         WR_CYCLES = 2
) (
    input  logic       clock_ctr,
    input  logic       sys_reset,
    input  logic       reset_ctr,
    input  logic [3:0] counter_type,
    input  logic [2:0] counter_param,
    input  logic [8:0] data_in,
    input  logic       write_param,
    input  logic       read_param,
    input  logic       reconfig,
    input  logic       pll_areset_in,
    output logic       busy,
    output logic [8:0] data_out,
    output logic       pll_scanclk,
    output logic       pll_scandata,
    output logic       pll_configupdate,
    output logic       pll_areset,
    output logic [9:0] m_total,
    output logic [9:0] n_total
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_SHIFT_L,
        ST_SHIFT_H,
        ST_UPDATE
    } state_t;

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    // Shadow index = {counter_type[0], counter_param[0]}: N_HI, N_LO, M_HI, M_LO
    localparam logic [8:0] SHADOW_DEF [4] = '{DEF_N_HI, DEF_N_LO, DEF_M_HI, DEF_M_LO};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;
    logic [5:0]       bit_reg, bit_next;
    logic [2:0]       req_now, req_prev_reg, req_rise;
    logic             wr_strobe, rd_start, rd_done, scan_start, apply_strobe;
    logic             addr_ok;
    logic [1:0]       addr_idx;
    logic [3:0][8:0]  shadow_w;
    logic [35:0]      scan_vec_reg;
    logic             rd_ok_reg;
    logic [1:0]       rd_idx_reg;
    logic [8:0]       data_out_reg;
    logic [8:0]       m_hi_app_reg, m_lo_app_reg, n_hi_app_reg, n_lo_app_reg;
    logic             pll_areset_reg;

    // Bit order: 0 = write, 1 = read, 2 = reconfig
    assign req_now  = {reconfig, read_param, write_param};
    assign addr_ok  = (counter_type < 4'd2) && (counter_param < 3'd2);
    assign addr_idx = {counter_type[0], counter_param[0]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rise
            assign req_rise[gi] = req_now[gi] & ~req_prev_reg[gi];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
            logic [8:0] sh_reg;
            always_ff @(posedge clock_ctr or posedge sys_reset) begin
                if (sys_reset) begin
                    sh_reg <= SHADOW_DEF[gi];
                end else if (reset_ctr) begin
                    sh_reg <= SHADOW_DEF[gi];
                end else if (wr_strobe && addr_ok && (addr_idx == 2'(gi))) begin
                    sh_reg <= data_in;
                end
            end
            assign shadow_w[gi] = sh_reg;
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        wr_cnt_next  = wr_cnt_reg;
        bit_next     = bit_reg;
        wr_strobe    = 1'b0;
        rd_start     = 1'b0;
        rd_done      = 1'b0;
        scan_start   = 1'b0;
        apply_strobe = 1'b0;
        if (reset_ctr) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_rise[2]) begin
                        scan_start = 1'b1;
                        bit_next   = 6'd35;
                        state_next = ST_SHIFT_L;
                    end else if (req_rise[0]) begin
                        wr_strobe   = 1'b1;
                        wr_cnt_next = CNT_W'(WR_CYCLES - 1);
                        state_next  = ST_WRITE;
                    end else if (req_rise[1]) begin
                        rd_start   = 1'b1;
                        state_next = ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        wr_cnt_next = wr_cnt_reg - 1'b1;
                    end
                end
                ST_READ: begin
                    rd_done    = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_SHIFT_L: state_next = ST_SHIFT_H;
                ST_SHIFT_H: begin
                    if (bit_reg == 6'd0) begin
                        state_next = ST_UPDATE;
                    end else begin
                        bit_next   = bit_reg - 6'd1;
                        state_next = ST_SHIFT_L;
                    end
                end
                ST_UPDATE: begin
                    apply_strobe = 1'b1;
                    state_next   = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset) begin
            state_reg    <= ST_IDLE;
            wr_cnt_reg   <= '0;
            bit_reg      <= 6'd0;
            req_prev_reg <= 3'b000;
        end else begin
            state_reg    <= state_next;
            wr_cnt_reg   <= wr_cnt_next;
            bit_reg      <= bit_next;
            req_prev_reg <= req_now;
        end
    end

    // Applied copies and read data survive reset_ctr; only sys_reset clears them.
    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset) begin
            scan_vec_reg   <= 36'd0;
            rd_ok_reg      <= 1'b0;
            rd_idx_reg     <= 2'd0;
            data_out_reg   <= 9'd0;
            m_hi_app_reg   <= DEF_M_HI;
            m_lo_app_reg   <= DEF_M_LO;
            n_hi_app_reg   <= DEF_N_HI;
            n_lo_app_reg   <= DEF_N_LO;
            pll_areset_reg <= 1'b0;
        end else begin
            pll_areset_reg <= pll_areset_in;
            if (scan_start) begin
                scan_vec_reg <= {shadow_w[2], shadow_w[3], shadow_w[0], shadow_w[1]};
            end
            if (rd_start) begin
                rd_ok_reg  <= addr_ok;
                rd_idx_reg <= addr_idx;
            end
            if (rd_done) begin
                data_out_reg <= rd_ok_reg ? shadow_w[rd_idx_reg] : 9'd0;
            end
            if (apply_strobe) begin
                {m_hi_app_reg, m_lo_app_reg, n_hi_app_reg, n_lo_app_reg} <= scan_vec_reg;
            end
        end
    end

    assign busy             = (state_reg != ST_IDLE);
    assign pll_scanclk      = (state_reg == ST_SHIFT_H);
    assign pll_scandata     = ((state_reg == ST_SHIFT_L) || (state_reg == ST_SHIFT_H))
                              ? scan_vec_reg[bit_reg] : 1'b0;
    assign pll_configupdate = (state_reg == ST_UPDATE);
    assign pll_areset       = pll_areset_reg;
    assign data_out         = data_out_reg;
    assign m_total          = {1'b0, m_hi_app_reg} + {1'b0, m_lo_app_reg};
    assign n_total          = {1'b0, n_hi_app_reg} + {1'b0, n_lo_app_reg};

endmodule
